// File: rtl/fib_job_sequencer.sv
// Fibonacci job sequencer: request FIFO, Fib core clr/start/done driver, response port.
// Optional golden-table result check when FIB_GOLDEN_CHECK_EN is defined.
module fib_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_n,
  output logic [2:0] fib_n,
  output logic       fib_clr,
  output logic       fib_start,
  input  logic       fib_done,
  input  logic [4:0] fib_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_n,
  output logic [4:0] rsp_result,
  output logic       rsp_timeout,
  output logic       rsp_error,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [9:0] LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, START, WAIT, RESP
  } state_t;

  state_t      state;
  logic [2:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [9:0]  cnt;
  logic [2:0]  job_n;
  logic        full;
  logic        empty;
  logic        push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready = !full;
  assign push  = req_valid && req_ready;
  assign busy  = (state != IDLE) || !empty;
  assign fib_n = job_n;
  assign rsp_n = job_n;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= req_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      job_n       <= '0;
      fib_clr     <= 1'b1;
      fib_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            job_n  <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          fib_clr   <= 1'b0;
          fib_start <= 1'b1;
          state     <= START;
        end
        START: begin
          fib_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (fib_done) begin
            rsp_result  <= fib_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            fib_clr     <= 1'b1;
            state       <= RESP;
          end else if (cnt == LAST) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            fib_clr     <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIB_GOLDEN_CHECK_EN
  function automatic logic [4:0] golden(input logic [2:0] n);
    logic [4:0] g;
    unique case (n)
      3'd0:    g = 5'd1;
      3'd1:    g = 5'd1;
      3'd2:    g = 5'd2;
      3'd3:    g = 5'd3;
      3'd4:    g = 5'd5;
      3'd5:    g = 5'd8;
      3'd6:    g = 5'd13;
      default: g = 5'd21;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_error <= 1'b0;
    end else if (state == WAIT) begin
      if (fib_done)
        rsp_error <= (fib_result != golden(job_n));
      else if (cnt == LAST)
        rsp_error <= 1'b1;
    end
  end
`else
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_fib_job_sequencer.sv
// Scoreboard bench for fib_job_sequencer with a behavioural Fib core model.
// Expected responses are queued at request accept and checked at response accept.
module tb_fib_job_sequencer;

`ifdef FIB_GOLDEN_CHECK_EN
  localparam int GOLD = 1;
`else
  localparam int GOLD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_n;
  logic [2:0] fib_n;
  logic       fib_clr;
  logic       fib_start;
  logic       fib_done = 1'b0;
  logic [4:0] fib_result = 5'd0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_n;
  logic [4:0] rsp_result;
  logic       rsp_timeout;
  logic       rsp_error;
  logic       busy;

  fib_job_sequencer #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .fib_n(fib_n), .fib_clr(fib_clr), .fib_start(fib_start),
    .fib_done(fib_done), .fib_result(fib_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] n;
    logic [4:0] r;
    logic       to;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int mode = 0;
  int lat = 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fib(input int n);
    int a = 1, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic int core_val(input int n);
    return (mode == 2 && n == 5) ? 9 : fib(n);
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] n);
    exp_t e;
    int r;
    e.n = n;
    if (mode == 1) begin
      e.r = '0; e.to = 1'b1; e.er = GOLD[0];
    end else begin
      r = core_val(int'(n));
      e.r = 5'(r); e.to = 1'b0;
      e.er = (GOLD != 0) && (r != fib(int'(n)));
    end
    return e;
  endfunction

  // Behavioural Fib core: done after lat cycles, cleared by clr
  int  ccnt = 0;
  bit  run = 0;
  always @(posedge clk) begin
    if (fib_clr) begin
      fib_done <= 1'b0;
      run <= 1'b0;
    end else if (fib_start) begin
      if (mode != 1) begin
        if (lat == 0) begin
          fib_done <= 1'b1;
          fib_result <= 5'(core_val(int'(fib_n)));
        end else begin
          run <= 1'b1;
          ccnt <= lat;
        end
      end
    end else if (run) begin
      if (ccnt == 1) begin
        run <= 1'b0;
        fib_done <= 1'b1;
        fib_result <= 5'(core_val(int'(fib_n)));
      end else begin
        ccnt <= ccnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_valid && req_ready) sb.push_back(mk_exp(req_n));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_n", rsp_n, e.n);
          chk("sb_result", rsp_result, e.r);
          chk("sb_timeout", rsp_timeout, e.to);
          chk("sb_error", rsp_error, e.er);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    int k = 0;
    req_n = 3'(n);
    req_valid = 1'b1;
    while (!req_ready && k < 1000) begin
      tick();
      k++;
    end
    chk("push_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    chk("drain_left", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_clr"}, fib_clr, 1);
    chk({p, "_start"}, fib_start, 0);
    chk({p, "_fib_n"}, fib_n, 0);
    chk({p, "_req_ready"}, req_ready, 1);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_n"}, rsp_n, 0);
    chk({p, "_rsp_result"}, rsp_result, 0);
    chk({p, "_rsp_timeout"}, rsp_timeout, 0);
    chk({p, "_rsp_error"}, rsp_error, 0);
    chk({p, "_busy"}, busy, 0);
  endtask

  initial begin
    int k;
    bit stable;
    req_valid = 1'b0;
    req_n = '0;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2 chk_reset_outs("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Minimum latency path with a zero-latency core
    mode = 0; lat = 0; rsp_ready = 1'b1;
    push(3);
    chk("lat_idle_busy", busy, 1);
    chk("lat_idle_start", fib_start, 0);
    tick();
    chk("lat_clear_n", fib_n, 3);
    chk("lat_clear_clr", fib_clr, 1);
    chk("lat_clear_start", fib_start, 0);
    tick();
    chk("lat_start_start", fib_start, 1);
    chk("lat_start_clr", fib_clr, 0);
    tick();
    chk("lat_wait_start", fib_start, 0);
    chk("lat_wait_valid", rsp_valid, 0);
    tick();
    chk("lat_resp_valid", rsp_valid, 1);
    chk("lat_resp_clr", fib_clr, 1);
    drain(20);

    // N = 0..7 back to back
    lat = int'($urandom_range(0, 3));
    for (int n = 0; n < 8; n++) push(n);
    drain(400);

    // Timeout with done held low
    mode = 1; rsp_ready = 1'b0;
    push(5);
    tick();
    tick();
    chk("to_start", fib_start, 1);
    k = 0;
    while (!rsp_valid && k < 400) begin
      tick();
      k++;
    end
    chk("to_latency", k, 256);
    chk("to_result", rsp_result, 0);
    chk("to_flag", rsp_timeout, 1);
    chk("to_error", rsp_error, GOLD);
    chk("to_n", rsp_n, 5);
    rsp_ready = 1'b1;
    drain(20);

    // Wrong core result, response held for 20 cycles with a job queued
    mode = 2; lat = 1; rsp_ready = 1'b0;
    push(5);
    push(2);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
    end
    chk("bad_valid", rsp_valid, 1);
    chk("bad_result", rsp_result, 9);
    chk("bad_error", rsp_error, GOLD);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!rsp_valid || rsp_n != 3'd5 || rsp_result != 5'd9 ||
          !fib_clr || fib_start || fib_n != 3'd5)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    rsp_ready = 1'b1;
    drain(100);

    // FIFO full with a stalled core
    mode = 1; rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) push(n);
    chk("full_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    push(5);
    drain(3000);

    // Reset during WAIT with requests queued
    mode = 1;
    push(1);
    push(2);
    push(3);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mode = 0; lat = 2;
    repeat (300) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", rsp_valid, 0);
    push(6);
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
